// File: rtl/grf_pkg.sv
// Shared definitions for the general register file.
// Holds the default configuration, the derived register count and pending
// limit for that configuration, and pop_match(), which counts how many
// enabled write ports target a given register.
// No ports.
package grf_pkg;

  localparam int DEF_DW      = 32;
  localparam int DEF_AW      = 5;
  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_NUM_WR  = 2;
  localparam int DEF_CNT_W   = 2;
  localparam int DEF_ZERO_R0 = 1;

  localparam int NREG     = 2 ** DEF_AW;
  localparam int PEND_MAX = 2 ** DEF_CNT_W - 1;

  // pop_match works on vectors padded to these limits so one function
  // serves every legal configuration (up to 8 ports, 8 address bits).
  localparam int MAX_PORTS = 8;
  localparam int MAX_AW    = 8;
  localparam int MAX_VEC   = MAX_PORTS * MAX_AW;

  function automatic int pop_match(input logic [MAX_VEC-1:0]   addr_vec,
                                   input logic [MAX_PORTS-1:0] en_vec,
                                   input logic [MAX_AW-1:0]    addr,
                                   input int                   n_ports,
                                   input int                   aw);
    int n;
    logic [MAX_VEC-1:0] mask;
    logic [MAX_VEC-1:0] field;
    n    = 0;
    mask = (MAX_VEC'(1) << aw) - MAX_VEC'(1);
    for (int k = 0; k < MAX_PORTS; k++) begin
      field = (addr_vec >> (k * aw)) & mask;
      if (k < n_ports && en_vec[k] && field == MAX_VEC'(addr)) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/grf_if.sv
// Bus bundle between the register file and the D/W pipeline stages.
// master: pipeline side (drives addresses, write data, issue requests).
// slave : register file side (returns read data, busy flags, full and error).
interface grf_if
  import grf_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
);

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic                 iss_full;
  logic                 sb_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, iss_full, sb_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, iss_full, sb_err
  );

endinterface

// File: rtl/grf_sb_cell.sv
// Pending-write counter for one register.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   inc        : an accepted issue targets this register this cycle
//   hits       : number of effective write ports retiring this register
//   pend       : outstanding write count
//   over       : more retirements than outstanding writes this cycle
module grf_sb_cell #(
  parameter int CNT_W = 2,
  parameter int HIT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [HIT_W-1:0] hits,
  output logic [CNT_W-1:0] pend,
  output logic             over
);

  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] pend_next;

  // Net change of issue and retire in one cycle; the count floors at 0.
  // sum cannot exceed the maximum because the issue is gated by iss_full.
  always_comb begin
    sum       = {1'b0, pend} + {{CNT_W{1'b0}}, inc};
    pend_next = '0;
    over      = 1'b0;
    if (int'(hits) > int'(sum)) over = 1'b1;
    if (int'(hits) < int'(sum)) pend_next = CNT_W'(int'(sum) - int'(hits));
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= pend_next;
  end

endmodule

// File: rtl/grf_multiport.sv
// Multi-port general register file with write-through bypass and a
// per-register pending-write scoreboard.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   bus        : grf_if slave -- read ports (rd_addr/rd_data/rd_busy),
//                write ports (wr_en/wr_addr/wr_data), issue (iss_en/iss_addr),
//                iss_full and the sticky sb_err flag.
module grf_multiport
  import grf_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int NUM_WR  = DEF_NUM_WR,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ZERO_R0 = DEF_ZERO_R0
) (
  input logic  clk,
  input logic  reset,
  grf_if.slave bus
);

  localparam int depth    = 2 ** AW;
  localparam int pend_max = 2 ** CNT_W - 1;
  localparam int hit_w    = $clog2(NUM_WR + 1);

  logic [NUM_WR-1:0]    ef;
  logic [DW-1:0]        regs [depth];
  logic [CNT_W-1:0]     pend [depth];
  logic [hit_w-1:0]     hits [depth];
  logic [depth-1:0]     inc;
  logic [depth-1:0]     over;
  logic                 full_raw;
  logic                 sb_err_q;
  logic [NUM_RD*DW-1:0] rd_data_c;
  logic [NUM_RD-1:0]    rd_busy_c;
  logic [AW-1:0]        rd_a;
  logic [DW-1:0]        rd_d;

  // Writes to r0 are not effective when r0 is hardwired, so they neither
  // bypass, store, nor retire anything.
  always_comb begin
    ef = '0;
    for (int k = 0; k < NUM_WR; k++)
      ef[k] = bus.wr_en[k] && !(ZERO_R0 != 0 && bus.wr_addr[k*AW +: AW] == '0);
  end

  assign full_raw = (pend[bus.iss_addr] == CNT_W'(pend_max));

  for (genvar r = 0; r < depth; r++) begin : g_sb
    assign hits[r] = hit_w'(pop_match(MAX_VEC'(bus.wr_addr), MAX_PORTS'(ef),
                                      MAX_AW'(r), NUM_WR, AW));
    assign inc[r]  = bus.iss_en && (bus.iss_addr == AW'(r)) && !full_raw &&
                     !(ZERO_R0 != 0 && r == 0);

    grf_sb_cell #(
      .CNT_W(CNT_W),
      .HIT_W(hit_w)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .inc  (inc[r]),
      .hits (hits[r]),
      .pend (pend[r]),
      .over (over[r])
    );
  end

  // Data array; ports are applied in ascending order so the highest index
  // wins when several target the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < depth; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++)
        if (ef[k]) regs[bus.wr_addr[k*AW +: AW]] <= bus.wr_data[k*DW +: DW];
    end
  end

  // Read ports: bypass from the highest matching write port, hardwired r0
  // overrides everything. Busy excludes writes retiring this cycle and
  // ignores the same-cycle issue, which belongs to a younger instruction.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    rd_a      = '0;
    rd_d      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a = bus.rd_addr[i*AW +: AW];
      rd_d = regs[rd_a];
      if (!reset) begin
        for (int k = 0; k < NUM_WR; k++)
          if (ef[k] && bus.wr_addr[k*AW +: AW] == rd_a) rd_d = bus.wr_data[k*DW +: DW];
      end
      if (ZERO_R0 != 0 && rd_a == '0) rd_d = '0;
      rd_data_c[i*DW +: DW] = rd_d;
      rd_busy_c[i] = !reset && (int'(pend[rd_a]) > int'(hits[rd_a]));
    end
  end

  // Sticky scoreboard error: a retirement found nothing outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sb_err_q <= 1'b0;
    else if (|over) sb_err_q <= 1'b1;
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.iss_full = !reset && full_raw;
  assign bus.sb_err   = sb_err_q;

endmodule
